// File: rtl/load_store_unit.sv
// Load/store unit: turns core byte/half/word requests into word-wide memory accesses.
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests return an error instead of being force-aligned.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_unsigned,
  input  logic [31:0] i_req_address,
  input  logic [31:0] i_req_data,
  output logic        o_resp_valid,
  output logic [31:0] o_resp_data,
  output logic        o_resp_error,
  output logic        o_mem_valid,
  output logic        o_mem_write,
  output logic [31:0] o_mem_address,
  output logic [31:0] o_mem_write_data,
  output logic [3:0]  o_mem_byte_enable,
  input  logic        i_mem_ready,
  input  logic [31:0] i_mem_read_data
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ACCESS  = 2'b01,
    RESPOND = 2'b10
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic [7:0]  cycle_count;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [1:0]  lat_offset;

  logic        misaligned;
  logic        req_trap;
  logic [31:0] eff_address;
  logic [3:0]  req_byte_enable;
  logic [31:0] req_write_data;
  logic [31:0] shifted_data;
  logic [31:0] load_data;

  // Request decode: alignment, byte lanes and store-data replication.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    misaligned      = 1'b0;
    eff_address     = i_req_address;
    req_byte_enable = 4'b0000;
    req_write_data  = 32'h0;
    case (i_req_size)
      SIZE_HALF: misaligned = i_req_address[0];
      SIZE_WORD: misaligned = |i_req_address[1:0];
      default:   misaligned = 1'b0;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    req_trap = (i_req_size == 2'b11) || misaligned;
`else
    req_trap = (i_req_size == 2'b11);
    if (i_req_size == SIZE_HALF)      eff_address[0]   = 1'b0;
    else if (i_req_size == SIZE_WORD) eff_address[1:0] = 2'b00;
`endif
    case (i_req_size)
      SIZE_BYTE: begin
        req_byte_enable = 4'b0001 << eff_address[1:0];
        req_write_data  = {4{i_req_data[7:0]}};
      end
      SIZE_HALF: begin
        req_byte_enable = 4'b0011 << {eff_address[1], 1'b0};
        req_write_data  = {2{i_req_data[15:0]}};
      end
      SIZE_WORD: begin
        req_byte_enable = 4'b1111;
        req_write_data  = i_req_data;
      end
      default: begin
        req_byte_enable = 4'b0000;
        req_write_data  = 32'h0;
      end
    endcase
  end

  // Load alignment and extension from the latched request shape.
  always_comb begin
    shifted_data = i_mem_read_data >> {lat_offset, 3'b000};
    case (lat_size)
      SIZE_BYTE: load_data = lat_unsigned ? {24'h0, shifted_data[7:0]}
                                          : {{24{shifted_data[7]}}, shifted_data[7:0]};
      SIZE_HALF: load_data = lat_unsigned ? {16'h0, shifted_data[15:0]}
                                          : {{16{shifted_data[15]}}, shifted_data[15:0]};
      default:   load_data = shifted_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments and an asynchronous reset,
  // so the memory cycle is dropped the instant i_reset rises, not at the next edge.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state             <= IDLE;
      cycle_count       <= 8'h0;
      lat_size          <= 2'b00;
      lat_unsigned      <= 1'b0;
      lat_offset        <= 2'b00;
      o_req_ready       <= 1'b1;
      o_resp_valid      <= 1'b0;
      o_resp_data       <= 32'h0;
      o_resp_error      <= 1'b0;
      o_mem_valid       <= 1'b0;
      o_mem_write       <= 1'b0;
      o_mem_address     <= 32'h0;
      o_mem_write_data  <= 32'h0;
      o_mem_byte_enable <= 4'b0000;
    end else begin
      o_resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req_valid && o_req_ready) begin
            lat_size          <= i_req_size;
            lat_unsigned      <= i_req_unsigned;
            lat_offset        <= eff_address[1:0];
            o_mem_write       <= i_req_write;
            o_mem_address     <= {eff_address[31:2], 2'b00};
            o_mem_write_data  <= req_write_data;
            o_mem_byte_enable <= req_byte_enable;
            o_req_ready       <= 1'b0;
            cycle_count       <= 8'h0;
            if (req_trap) begin
              state        <= RESPOND;
              o_resp_valid <= 1'b1;
              o_resp_error <= 1'b1;
              o_resp_data  <= 32'h0;
            end else begin
              state       <= ACCESS;
              o_mem_valid <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (i_mem_ready) begin
            state        <= RESPOND;
            o_mem_valid  <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_error <= 1'b0;
            o_resp_data  <= o_mem_write ? 32'h0 : load_data;
          end else if (cycle_count == TIMEOUT_LAST) begin
            // Memory never answered: give up with an error response.
            state        <= RESPOND;
            o_mem_valid  <= 1'b0;
            o_resp_valid <= 1'b1;
            o_resp_error <= 1'b1;
            o_resp_data  <= 32'h0;
          end else begin
            cycle_count <= cycle_count + 8'h1;
          end
        end
        RESPOND: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
        end
        default: begin
          state       <= IDLE;
          o_req_ready <= 1'b1;
          o_mem_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TIMEOUT_CYCLES=4); honours LSU_MISALIGN_TRAP_EN if defined.
module tb_load_store_unit;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_write;
  logic [1:0]  i_req_size;
  logic        i_req_unsigned;
  logic [31:0] i_req_address;
  logic [31:0] i_req_data;
  logic        o_resp_valid;
  logic [31:0] o_resp_data;
  logic        o_resp_error;
  logic        o_mem_valid;
  logic        o_mem_write;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_byte_enable;
  logic        i_mem_ready;
  logic [31:0] i_mem_read_data;

  int n_checks = 0;
  int n_fail   = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk             (i_clk),
    .i_reset           (i_reset),
    .i_req_valid       (i_req_valid),
    .o_req_ready       (o_req_ready),
    .i_req_write       (i_req_write),
    .i_req_size        (i_req_size),
    .i_req_unsigned    (i_req_unsigned),
    .i_req_address     (i_req_address),
    .i_req_data        (i_req_data),
    .o_resp_valid      (o_resp_valid),
    .o_resp_data       (o_resp_data),
    .o_resp_error      (o_resp_error),
    .o_mem_valid       (o_mem_valid),
    .o_mem_write       (o_mem_write),
    .o_mem_address     (o_mem_address),
    .o_mem_write_data  (o_mem_write_data),
    .o_mem_byte_enable (o_mem_byte_enable),
    .i_mem_ready       (i_mem_ready),
    .i_mem_read_data   (i_mem_read_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Presents one request and returns just after its accept edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    @(negedge i_clk);
    i_req_valid    = 1'b1;
    i_req_write    = w;
    i_req_size     = sz;
    i_req_unsigned = u;
    i_req_address  = a;
    i_req_data     = d;
    @(posedge i_clk);
    #1 i_req_valid = 1'b0;
  endtask

  // Access with memory ready at once: check mem side at N+1, response at N+2, idle at N+3.
  task automatic run(input string tag, input logic w, input logic [1:0] sz, input logic u,
                     input logic [31:0] a, input logic [31:0] d, input logic [31:0] rdata,
                     input logic [31:0] exp_addr, input logic [3:0] exp_be,
                     input logic [31:0] exp_wdata, input logic [31:0] exp_resp);
    i_mem_ready     = 1'b1;
    i_mem_read_data = rdata;
    send(w, sz, u, a, d);
    @(negedge i_clk);
    check({tag, ".mem_valid"}, o_mem_valid, 1);
    check({tag, ".req_ready"}, o_req_ready, 0);
    check({tag, ".mem_write"}, o_mem_write, w);
    check({tag, ".mem_addr"},  o_mem_address, exp_addr);
    check({tag, ".be"},        o_mem_byte_enable, exp_be);
    if (w) check({tag, ".wdata"}, o_mem_write_data, exp_wdata);
    check({tag, ".early_resp"}, o_resp_valid, 0);
    @(posedge i_clk);
    #1 i_mem_ready = 1'b0;
    @(negedge i_clk);
    check({tag, ".resp_valid"}, o_resp_valid, 1);
    check({tag, ".resp_data"},  o_resp_data, exp_resp);
    check({tag, ".resp_error"}, o_resp_error, 0);
    check({tag, ".mem_dropped"}, o_mem_valid, 0);
    @(negedge i_clk);
    check({tag, ".resp_once"}, o_resp_valid, 0);
    check({tag, ".ready_back"}, o_req_ready, 1);
  endtask

  // Request rejected without a memory cycle: error response at N+1.
  task automatic run_err(input string tag, input logic [1:0] sz, input logic [31:0] a);
    i_mem_ready = 1'b1;
    send(1'b0, sz, 1'b0, a, 32'h0);
    @(negedge i_clk);
    check({tag, ".mem_valid"},  o_mem_valid, 0);
    check({tag, ".resp_valid"}, o_resp_valid, 1);
    check({tag, ".resp_error"}, o_resp_error, 1);
    check({tag, ".resp_data"},  o_resp_data, 0);
    @(negedge i_clk);
    check({tag, ".resp_once"}, o_resp_valid, 0);
    check({tag, ".ready_back"}, o_req_ready, 1);
    i_mem_ready = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mem_cycles;
    int resp_count;
    int resp_at;

    i_reset         = 1'b1;
    i_req_valid     = 1'b0;
    i_req_write     = 1'b0;
    i_req_size      = 2'b00;
    i_req_unsigned  = 1'b0;
    i_req_address   = 32'h0;
    i_req_data      = 32'h0;
    i_mem_ready     = 1'b0;
    i_mem_read_data = 32'h0;

    repeat (2) @(negedge i_clk);
    check("rst.req_ready",  o_req_ready, 1);
    check("rst.resp_valid", o_resp_valid, 0);
    check("rst.resp_data",  o_resp_data, 0);
    check("rst.resp_error", o_resp_error, 0);
    check("rst.mem_valid",  o_mem_valid, 0);
    check("rst.mem_write",  o_mem_write, 0);
    check("rst.mem_addr",   o_mem_address, 0);
    check("rst.mem_wdata",  o_mem_write_data, 0);
    check("rst.mem_be",     o_mem_byte_enable, 0);
    i_reset = 1'b0;

    run("lw100",  1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF,
        32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
    run("lb103",  1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h80112233,
        32'h100, 4'b1000, 32'h0, 32'hFFFFFF80);
    run("lbu103", 1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h80112233,
        32'h100, 4'b1000, 32'h0, 32'h00000080);
    run("sh22",   1'b1, 2'b01, 1'b0, 32'h22, 32'h0000ABCD, 32'h55555555,
        32'h20, 4'b1100, 32'hABCDABCD, 32'h0);
    run("sb101",  1'b1, 2'b00, 1'b0, 32'h101, 32'h12345678, 32'h0,
        32'h100, 4'b0010, 32'h78787878, 32'h0);
    run("sw104",  1'b1, 2'b10, 1'b0, 32'h104, 32'hA5A5_0F0F, 32'h0,
        32'h104, 4'b1111, 32'hA5A50F0F, 32'h0);
    run("lh102",  1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 32'h80017FFF,
        32'h100, 4'b1100, 32'h0, 32'hFFFF8001);
    run("lhu100", 1'b0, 2'b01, 1'b1, 32'h100, 32'h0, 32'h80017FFF,
        32'h100, 4'b0011, 32'h0, 32'h00007FFF);

    run_err("size11", 2'b11, 32'h200);

`ifdef LSU_MISALIGN_TRAP_EN
    run_err("lw101_trap", 2'b10, 32'h101);
`else
    run("lw101_align", 1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'hCAFEF00D,
        32'h100, 4'b1111, 32'h0, 32'hCAFEF00D);
`endif

    // Memory never ready: four cycles of o_mem_valid, then error response at N+5.
    i_mem_ready = 1'b0;
    mem_cycles  = 0;
    resp_count  = 0;
    resp_at     = -1;
    send(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      if (o_mem_valid) mem_cycles++;
      if (o_resp_valid) begin
        resp_count++;
        resp_at = i;
        check("tmo.resp_error", o_resp_error, 1);
        check("tmo.resp_data",  o_resp_data, 0);
      end
    end
    check("tmo.mem_cycles", mem_cycles, 4);
    check("tmo.resp_count", resp_count, 1);
    check("tmo.resp_at",    resp_at, 4);
    check("tmo.ready_back", o_req_ready, 1);

    // Reset in the middle of ACCESS aborts the transaction silently.
    send(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
    @(negedge i_clk);
    check("rstacc.mem_valid_before", o_mem_valid, 1);
    #1 i_reset = 1'b1;
    #1;
    check("rstacc.mem_valid_now", o_mem_valid, 0);
    check("rstacc.req_ready_now", o_req_ready, 1);
    #1 i_reset = 1'b0;
    resp_count = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_resp_valid) resp_count++;
    end
    check("rstacc.no_resp",   resp_count, 0);
    check("rstacc.req_ready", o_req_ready, 1);
    check("rstacc.mem_idle",  o_mem_valid, 0);

    // Unit still works after the abort.
    run("lw_after_rst", 1'b0, 2'b10, 1'b0, 32'h500, 32'h0, 32'h01234567,
        32'h500, 4'b1111, 32'h0, 32'h01234567);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max cycles to wait for i_mem_ready before an error response (1..255).
REQ-002 SHALL have port i_clk  input  1  clock; all state changes on its rising edge.
REQ-003 SHALL have port i_reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_req_valid  input  1  core request present.
REQ-005 SHALL have port o_req_ready  output  1  unit can accept a request.
REQ-006 SHALL have port i_req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port i_req_size  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-008 SHALL have port i_req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
REQ-009 SHALL have port i_req_address  input  32  byte address.
REQ-010 SHALL have port i_req_data  input  32  store data, right-aligned.
REQ-011 SHALL have port o_resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port o_resp_data  output  32  extended load data; 0 for stores and errors.
REQ-013 SHALL have port o_resp_error  output  1  qualifies o_resp_valid; access failed.
REQ-014 SHALL have ports o_mem_valid (output 1), o_mem_write (output 1), o_mem_address (output 32, bits[1:0]=0), o_mem_write_data (output 32), o_mem_byte_enable (output 4), i_mem_ready (input 1), i_mem_read_data (input 32): word-wide memory handshake.

Function
REQ-015 SHALL implement FSM IDLE -> ACCESS -> RESPOND -> IDLE; o_req_ready = 1 only in IDLE.
REQ-016 SHALL latch all request fields on i_req_valid && o_req_ready and move to ACCESS, or straight to RESPOND with error for size 11 (no memory cycle).
REQ-017 SHALL hold o_mem_valid=1 and all o_mem_* stable throughout ACCESS; leave ACCESS on the edge where i_mem_ready=1, capturing i_mem_read_data.
REQ-018 SHALL give best-case latency: accept edge N, o_mem_valid high in cycle N+1, o_resp_valid high in cycle N+2 if i_mem_ready=1 in N+1.
REQ-019 SHALL assert o_resp_valid for exactly one cycle in RESPOND, then return to IDLE; no back-pressure on responses.
REQ-020 SHALL count ACCESS cycles (8-bit counter, cleared on entry); if TIMEOUT_CYCLES cycles elapse without i_mem_ready, go to RESPOND with o_resp_error=1, o_resp_data=0, drop o_mem_valid.
REQ-021 SHALL drive byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<(2*addr[1]); word 4'b1111; also on loads.
REQ-022 SHALL replicate store data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-023 SHALL extract loads by shifting read data right by 8*addr[1:0], then sign- or zero-extend from bit 7 (byte) or 15 (half).
REQ-024 SHALL treat half with addr[0]=1 or word with addr[1:0]!=0 as misaligned, handled per REQ-028.
REQ-025 SHALL drive o_resp_data=0 and o_resp_error=0 for successful stores; o_resp_error=0 on every successful load.

Reset
REQ-026 SHALL on i_reset force state IDLE immediately, abort any transaction with no response, and clear counter and latched fields.
REQ-027 SHALL hold reset values: o_req_ready=1, o_resp_valid=0, o_resp_data=0, o_resp_error=0, o_mem_valid=0, o_mem_write=0, o_mem_address=0, o_mem_write_data=0, o_mem_byte_enable=0.

Configuration
REQ-028 SHALL, with LSU_MISALIGN_TRAP_EN defined, send a misaligned request straight to RESPOND with o_resp_error=1 and no memory cycle; without it, SHALL clear the offending low address bits (half: bit 0; word: bits 1:0) and perform the access normally.

Verification
REQ-029 SHALL cover word load addr 0x100, mem ready immediately, read 0xDEADBEEF -> o_mem_byte_enable=1111, o_resp_valid at N+2, data 0xDEADBEEF, error 0.
REQ-030 SHALL cover signed byte load addr 0x103, read 0x80112233 -> byte enable 1000, resp data 0xFFFFFF80; same access unsigned -> 0x00000080.
REQ-031 SHALL cover half store addr 0x22, data 0x0000ABCD -> o_mem_address 0x20, write_data 0xABCDABCD, byte enable 1100, resp data 0, error 0.
REQ-032 SHALL cover i_mem_ready held 0, TIMEOUT_CYCLES=4 -> o_mem_valid for exactly 4 cycles, then one-cycle resp with error 1, data 0.
REQ-033 SHALL cover word load addr 0x101 -> with LSU_MISALIGN_TRAP_EN: no o_mem_valid, error 1 at N+1; without it: o_mem_address 0x100, normal response.
REQ-034 SHALL cover i_reset asserted while in ACCESS -> o_mem_valid low immediately, no o_resp_valid, o_req_ready=1 next cycle.
